// File: rtl/fp_pkg.sv
// Shared types and field helpers for the mini-float add/subtract unit.
// Field helpers take widths as arguments so any EXP_W/FRAC_W instance can reuse them.
package fp_pkg;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    localparam int FLD_W = 32;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic fld_sign(input logic [FLD_W-1:0] word, input int exp_w, input int frac_w);
        return word[exp_w + frac_w];
    endfunction

    function automatic logic [FLD_W-1:0] fld_exp(input logic [FLD_W-1:0] word, input int exp_w, input int frac_w);
        return (word >> frac_w) & ((FLD_W'(1) << exp_w) - FLD_W'(1));
    endfunction

    function automatic logic [FLD_W-1:0] fld_frac(input logic [FLD_W-1:0] word, input int exp_w, input int frac_w);
        return word & ((FLD_W'(1) << frac_w) - FLD_W'(1));
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand, with mantissa-carry renormalisation
// and saturation to the largest finite value. Purely combinational.
module fp_round_rne #(
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4
) (
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_sticky,
    input  logic [EXP_W:0]    i_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_ovf
);

    localparam logic [EXP_W:0] EXP_ONES = (EXP_W+1)'(2**EXP_W - 1);

    logic              w_up;
    logic [FRAC_W:0]   w_inc;
    logic [EXP_W:0]    w_exp;

    always_comb begin
        w_up   = i_g & (i_r | i_sticky | i_frac[0]);
        w_inc  = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_up};
        // A carry out of the fraction means 10.000..: frac wraps to 0 and exp steps up.
        w_exp  = i_exp + {{EXP_W{1'b0}}, w_inc[FRAC_W]};
        o_frac = w_inc[FRAC_W-1:0];
        o_exp  = w_exp[EXP_W-1:0];
        o_ovf  = 1'b0;
        if (i_exp == '0) begin
            o_frac = '0;
            o_exp  = '0;
        end else if (w_exp >= EXP_ONES) begin
            o_ovf  = 1'b1;
            o_exp  = EXP_ONES[EXP_W-1:0] - EXP_W'(1);
            o_frac = '1;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Iterative mini-float add/subtract: align one bit per cycle, add, normalise, round (RNE).
// Latency d+k+4 from accept; one op in flight; DONE holds the result until out_ready.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter  int EXP_W  = 3,
    parameter  int FRAC_W = 4,
    localparam int W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf
);

    localparam int SW = FRAC_W + 4;
    localparam int XW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_SAT  = EXP_W'(2**EXP_W - 2);

    state_t r_state, w_state_nxt;

    logic [SW-1:0]    r_sig_big, r_sig_small;
    logic [EXP_W-1:0] r_diff;
    logic [XW-1:0]    r_exp;
    logic             r_sign, r_sub, r_sticky, r_flush;
    logic [W-1:0]     r_result;
    logic             r_ovf, r_unf;

    logic             w_sa, w_sb, w_a_big, w_collapse;
    logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_small, w_diff;
    logic [FRAC_W-1:0] w_fa, w_fb;
    logic [SW-1:0]    w_sig_a, w_sig_b, w_sig_l, w_sig_s, w_sum;
    logic [FRAC_W-1:0] w_rnd_frac;
    logic [EXP_W-1:0] w_rnd_exp;
    logic             w_rnd_ovf;

    always_comb begin
        w_sa = fld_sign(FLD_W'(a), EXP_W, FRAC_W);
        w_sb = fld_sign(FLD_W'(b), EXP_W, FRAC_W) ^ op;
        w_ea = EXP_W'(fld_exp(FLD_W'(a), EXP_W, FRAC_W));
        w_eb = EXP_W'(fld_exp(FLD_W'(b), EXP_W, FRAC_W));
        w_fa = FRAC_W'(fld_frac(FLD_W'(a), EXP_W, FRAC_W));
        w_fb = FRAC_W'(fld_frac(FLD_W'(b), EXP_W, FRAC_W));
        // Reserved all-ones exponent reads as the largest finite value; zero ignores frac.
        if (w_ea == EXP_ONES) begin w_ea = EXP_SAT; w_fa = '1; end
        if (w_eb == EXP_ONES) begin w_eb = EXP_SAT; w_fb = '1; end
        if (w_ea == '0) w_fa = '0;
        if (w_eb == '0) w_fb = '0;
        w_sig_a    = (w_ea == '0) ? '0 : {2'b01, w_fa, 2'b00};
        w_sig_b    = (w_eb == '0) ? '0 : {2'b01, w_fb, 2'b00};
        w_a_big    = ({w_ea, w_fa} >= {w_eb, w_fb});
        w_e_big    = w_a_big ? w_ea : w_eb;
        w_e_small  = w_a_big ? w_eb : w_ea;
        w_sig_l    = w_a_big ? w_sig_a : w_sig_b;
        w_sig_s    = w_a_big ? w_sig_b : w_sig_a;
        w_diff     = w_e_big - w_e_small;
        w_collapse = (32'(w_diff) > FRAC_W + 3);
        // Sticky acts as a borrow from below R when the magnitudes are subtracted.
        w_sum      = r_sub ? (r_sig_big - r_sig_small - SW'(r_sticky))
                           : (r_sig_big + r_sig_small);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (in_valid) w_state_nxt = ALIGN;
            ALIGN: if (r_diff == '0) w_state_nxt = ADD;
            ADD:   w_state_nxt = NORM;
            NORM:  if (r_sig_big == '0 || r_sig_big[SW-2] || r_exp == XW'(1)) w_state_nxt = ROUND;
            ROUND: w_state_nxt = DONE;
            DONE:  if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_big   <= '0;
            r_sig_small <= '0;
            r_diff      <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_sub       <= 1'b0;
            r_sticky    <= 1'b0;
            r_flush     <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_sign    <= w_a_big ? w_sa : w_sb;
                    r_sub     <= w_sa ^ w_sb;
                    r_exp     <= {1'b0, w_e_big};
                    r_sig_big <= w_sig_l;
                    r_flush   <= 1'b0;
                    if (w_collapse) begin
                        r_sig_small <= '0;
                        r_sticky    <= (w_sig_s != '0);
                        r_diff      <= '0;
                    end else begin
                        r_sig_small <= w_sig_s;
                        r_sticky    <= 1'b0;
                        r_diff      <= w_diff;
                    end
                end
                ALIGN: if (r_diff != '0) begin
                    r_sig_small <= r_sig_small >> 1;
                    r_sticky    <= r_sticky | r_sig_small[0];
                    r_diff      <= r_diff - EXP_W'(1);
                end
                ADD: if (w_sum[SW-1]) begin
                    r_sig_big <= w_sum >> 1;
                    r_exp     <= r_exp + XW'(1);
                    r_sticky  <= r_sticky | w_sum[0];
                end else begin
                    r_sig_big <= w_sum;
                end
                NORM: if (r_sig_big == '0) begin
                    r_exp  <= '0;
                    r_sign <= 1'b0;
                end else if (!r_sig_big[SW-2] && r_exp == XW'(1)) begin
                    r_sig_big <= '0;
                    r_exp     <= '0;
                    r_sign    <= 1'b0;
                    r_sticky  <= 1'b0;
                    r_flush   <= 1'b1;
                end else if (!r_sig_big[SW-2]) begin
                    r_sig_big <= r_sig_big << 1;
                    r_exp     <= r_exp - XW'(1);
                end
                ROUND: begin
                    r_result <= {r_sign, w_rnd_exp, w_rnd_frac};
                    r_ovf    <= w_rnd_ovf;
                    r_unf    <= r_flush;
                end
                default: ;
            endcase
        end
    end

    fp_round_rne #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
        .i_frac   (r_sig_big[FRAC_W+1:2]),
        .i_g      (r_sig_big[1]),
        .i_r      (r_sig_big[0]),
        .i_sticky (r_sticky),
        .i_exp    (r_exp),
        .o_frac   (w_rnd_frac),
        .o_exp    (w_rnd_exp),
        .o_ovf    (w_rnd_ovf)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq at EXP_W=3, FRAC_W=4: directed vectors, handshake corners,
// mid-operation reset, and random operands against an exact-arithmetic reference.
module tb_fp_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       op = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, ovf, unf;
    logic [7:0] result;

    int n_chk  = 0;
    int n_fail = 0;

    fp_addsub_seq #(.EXP_W(3), .FRAC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] res;
        logic       ov;
        logic       un;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact value in units of 2^-6, rounded to 5 significant bits, nearest-even.
    task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic iop,
                         output logic [7:0] r, output logic ov, output logic un, output int lat);
        int ea, fa, eb, fb, ma, mb, s, mag, e, sig, rem, half, ebig, esml, d, k, lg;
        logic sa, sb;
        ea = int'(ia[6:4]); fa = int'(ia[3:0]);
        eb = int'(ib[6:4]); fb = int'(ib[3:0]);
        if (ea == 7) begin ea = 6; fa = 15; end
        if (eb == 7) begin eb = 6; fb = 15; end
        ma = (ea == 0) ? 0 : (16 + fa) << (ea - 1);
        mb = (eb == 0) ? 0 : (16 + fb) << (eb - 1);
        sa = ia[7];
        sb = ib[7] ^ iop;
        s  = (sa ? -ma : ma) + (sb ? -mb : mb);
        if (ma >= mb) begin ebig = ea; esml = eb; end
        else          begin ebig = eb; esml = ea; end
        d = ebig - esml;
        if (d > 7) d = 0;
        r = 8'h00; ov = 1'b0; un = 1'b0; k = 0;
        if (s != 0) begin
            mag = (s < 0) ? -s : s;
            if (mag < 16) begin
                un = 1'b1;
                k  = ebig - 1;
            end else begin
                lg = 0;
                while ((mag >> (lg + 1)) != 0) lg++;
                e   = lg - 3;
                k   = (e < ebig) ? ebig - e : 0;
                sig = mag >> (e - 1);
                rem = mag - (sig << (e - 1));
                if (e >= 2) begin
                    half = 1 << (e - 2);
                    if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
                end
                if (sig == 32) begin sig = 16; e++; end
                if (e >= 7) begin
                    ov = 1'b1;
                    r  = {(s < 0), 3'd6, 4'hF};
                end else begin
                    r[7]   = (s < 0);
                    r[6:4] = 3'(e);
                    r[3:0] = 4'(sig - 16);
                end
            end
        end
        lat = d + k + 4;
    endtask

    // Full transaction: accept, measure latency, optionally stall out_ready while
    // presenting a competing operand, then complete the handshake.
    task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic iop, input int hold, input logic [7:0] er,
                          input logic eov, input logic eun, input int elat);
        int guard;
        int lat;
        @(negedge clk);
        a = ia; b = ib; op = iop; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!in_ready) check({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 100);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, 32'(result), 32'(er));
        check({name, "_ovf"}, 32'(ovf), 32'(eov));
        check({name, "_unf"}, 32'(unf), 32'(eun));
        check({name, "_latency"}, 32'(lat), 32'(elat));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 8'h30; b = 8'h30; op = 1'b0;
            @(posedge clk); #1;
            check({name, "_hold_result"}, 32'(result), 32'(er));
            check({name, "_hold_ovf"}, 32'(ovf), 32'(eov));
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, 32'(out_valid), 32'd0);
        check({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb, mr;
        logic       rop, mov, mun;
        int         mlat;
        bit         seen;

        #1 rst_n = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'({ovf, unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{8'h30, 8'h30, 1'b0, 8'h40, 1'b0, 1'b0, 4};
        vecs[1]  = '{8'h40, 8'h30, 1'b0, 8'h48, 1'b0, 1'b0, 5};
        vecs[2]  = '{8'h30, 8'h30, 1'b1, 8'h00, 1'b0, 1'b0, 4};
        vecs[3]  = '{8'h60, 8'h10, 1'b0, 8'h60, 1'b0, 1'b0, 9};
        vecs[4]  = '{8'h61, 8'h10, 1'b0, 8'h62, 1'b0, 1'b0, 9};
        vecs[5]  = '{8'h6F, 8'h6F, 1'b0, 8'h6F, 1'b1, 1'b0, 4};
        vecs[6]  = '{8'h11, 8'h10, 1'b1, 8'h00, 1'b0, 1'b1, 4};
        vecs[7]  = '{8'h00, 8'h30, 1'b0, 8'h30, 1'b0, 1'b0, 7};
        vecs[8]  = '{8'h30, 8'h40, 1'b1, 8'hB0, 1'b0, 1'b0, 6};
        vecs[9]  = '{8'h70, 8'h00, 1'b0, 8'h6F, 1'b0, 1'b0, 10};
        vecs[10] = '{8'h3F, 8'h3F, 1'b0, 8'h4F, 1'b0, 1'b0, 4};
        vecs[11] = '{8'hB0, 8'hB0, 1'b0, 8'hC0, 1'b0, 1'b0, 4};
        vecs[12] = '{8'h60, 8'h1F, 1'b1, 8'h5E, 1'b0, 1'b0, 10};

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, 0,
                   vecs[i].res, vecs[i].ov, vecs[i].un, vecs[i].lat);

        // Reserved b=0x70 reads as 0x6F; the tie rounds up into saturation.
        run_op("hold_sat", 8'h10, 8'h70, 1'b0, 5, 8'h6F, 1'b1, 1'b0, 9);

        @(negedge clk);
        a = 8'h60; b = 8'h10; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_unf", 32'(unf), 32'd0);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 32'd0);
        run_op("after_rst", 8'h40, 8'h30, 1'b0, 0, 8'h48, 1'b0, 1'b0, 5);

        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 1'($urandom_range(0, 1));
            model(ra, rb, rop, mr, mov, mun, mlat);
            run_op($sformatf("rand%0d_%02h_%02h_%0d", i, ra, rb, rop), ra, rb, rop,
                   (i % 37 == 0) ? 2 : 0, mr, mov, mun, mlat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Parametrised sequential floating-point adder/subtractor for the team's mini-float datapath. Generalises the 8-bit compare/align front end into a complete iterative unit that:
- compares the operands and aligns the smaller one, one shift per cycle;
- adds or subtracts the significands;
- normalises, then rounds to nearest-even.

It sits between operand registers and the result bus, using a valid/ready handshake on both sides.

## Interface
- EXP_W, default 3: exponent field width (≥2); bias = 2^(EXP_W-1)-1.
- FRAC_W, default 4: stored fraction width (≥2); hidden leading 1.
- W = 1+EXP_W+FRAC_W (derived localparam): word layout is {sign, exp, frac}.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle, can accept.
- a, b  in  W each  operands.
- op  in  1  0 = a+b, 1 = a−b (inverts b's sign at accept).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- result  out  W  rounded sum.
- ovf, unf  out  1 each  saturated / flushed-to-zero flags, valid with out_valid.

## Operation
- Encoding:
  - exp==0 means zero, and the fraction is ignored.
  - exp==all-ones is reserved. Such an input is treated as the largest finite value {s, all-ones−1, all-ones frac}.
  - No inf, NaN or subnormals.
- Internal significand = {carry, hidden, frac, G, R}; a sticky bit is kept separately.
- FSM states and transitions:
  - IDLE → ALIGN on in_valid&&in_ready. At the accept edge the block:
    - captures the operands;
    - swaps them so that big has the larger magnitude (exp first, then frac);
    - loads diff = exp_big − exp_small.
    - If diff > FRAC_W+3, small is collapsed at load time: significand = 0, sticky = (small≠0), diff = 0.
  - ALIGN: if diff==0 → ADD. Otherwise shift small right by 1, diff−1, and OR the bit shifted out into sticky.
  - ADD:
    - Signs equal → add. Signs differ → big − small, with sticky treated as a borrow into the bits below R.
    - Result sign = sign of big.
    - On carry out: shift right 1, exp+1, OR the dropped bit into sticky.
    - → NORM.
  - NORM, checked in this priority order:
    - significand==0 → result +0, → ROUND.
    - hidden bit 0 and exp==1 → flush to zero, set unf, → ROUND.
    - hidden bit 0 → shift left 1, exp−1, stay in NORM.
    - otherwise → ROUND.
  - ROUND:
    - Round to nearest-even using G, R and sticky.
    - If the mantissa overflows, renormalise and exp+1.
    - If exp ≥ all-ones, saturate to {sign, all-ones−1, all-ones} and set ovf.
    - → DONE.
  - DONE: out_valid=1. On out_ready → IDLE.
- Exact zero result is always +0.
- in_ready = (state==IDLE).
- result, ovf and unf are registered and stay stable while out_valid=1.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, ovf=0, unf=0, all internal registers 0.
- Latency from the accept edge to out_valid rising is d+k+4 cycles:
  - d = alignment shifts, min(diff, FRAC_W+3) before collapse, and 0 after collapse;
  - k = normalisation left shifts.
- Throughput: one operation in flight at a time. A new accept is possible in the cycle after the DONE handshake.
- When out_ready is low, DONE holds indefinitely with the outputs unchanged.
- in_valid during a busy state is ignored; the operand is not consumed.
- rst_n asserted mid-operation aborts immediately to the reset values. No result is produced.
- Asynchronous assert, synchronous-safe deassert is handled externally.

## Structure
- Package fp_pkg holds:
  - the state enum (IDLE, ALIGN, ADD, NORM, ROUND, DONE);
  - a bias function of EXP_W;
  - the field-extract helper functions.
- One combinational sub-module, fp_round_rne. Its inputs are the significand, G, R, sticky and exp; its outputs are the rounded fraction, the exponent and ovf.
- Top module: the FSM plus the datapath registers.

## Test plan
(EXP_W=3, FRAC_W=4)
- a=0x30, b=0x30, op=0 → result 0x40 (2.0), out_valid 4 cycles after accept, flags 0.
- a=0x40, b=0x30, op=0 → 0x48 (3.0), latency 5 (d=1). a=0x30, b=0x30, op=1 → 0x00, unf=0.
- Ties round to even:
  - a=0x60, b=0x10 → 0x60 (8+0.25), latency 9.
  - a=0x61, b=0x10 → 0x62 (8.75 → 9.0).
- a=0x6F, b=0x6F → 0x6F with ovf=1. a=0x11, b=0x10, op=1 → 0x00 with unf=1.
- Hold out_ready low for 5 cycles → result stable and in_ready=0 throughout; b=0x70 is treated as 0x6F.
- Pulse rst_n low during ALIGN → outputs return to reset values, out_valid never asserts, next op correct.
